// File: rtl/tjmono_readout_ctrl.sv
// rtl/tjmono_readout_ctrl.sv - TJ-Monopix dual-flavour readout sequencer
// Round-robin grant between flavours A/B, then freeze / read-pulse / release framing.
module tjmono_readout_ctrl #(
  parameter int unsigned FREEZE_DLY  = 4,
  parameter int unsigned READ_HI_LEN = 1,
  parameter int unsigned READ_LO_LEN = 3,
  parameter int unsigned RELEASE_LEN = 2,
  parameter int unsigned MAX_WORDS   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        EN_A,
  input  logic        EN_B,
  input  logic        TOK_A,
  input  logic        TOK_B,
  output logic        FREEZE_A,
  output logic        FREEZE_B,
  output logic        READ_A,
  output logic        READ_B,
  output logic        SEL,
  output logic        DATA_STROBE,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW,
  output logic [15:0] WORD_CNT,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FREEZE, ST_READ_HI, ST_READ_LO, ST_RELEASE
  } state_t;

  localparam logic [7:0]  LEN_FREEZE  = 8'(FREEZE_DLY);
  localparam logic [7:0]  LEN_HI      = 8'(READ_HI_LEN);
  localparam logic [7:0]  LEN_LO      = 8'(READ_LO_LEN);
  localparam logic [7:0]  LEN_REL     = 8'(RELEASE_LEN);
  localparam logic [15:0] WORD_LIMIT  = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tok_a_meta_q, tok_a_meta_d, ts_a_q, ts_a_d;
  logic        tok_b_meta_q, tok_b_meta_d, ts_b_q, ts_b_d;
  logic        gnt_b_q, gnt_b_d, last_b_q, last_b_d, sel_q, sel_d;
  logic        freeze_a_q, freeze_a_d, freeze_b_q, freeze_b_d;
  logic        read_a_q, read_a_d, read_b_q, read_b_d;
  logic        strobe_q, strobe_d, busy_q, busy_d;
  logic        frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic [15:0] word_cnt_q, word_cnt_d, frame_cnt_q, frame_cnt_d;
  logic        req_a, req_b, ts_gnt, frame_active;
  logic [15:0] word_inc;

  always_comb begin
    tok_a_meta_d = TOK_A;
    ts_a_d       = tok_a_meta_q;
    tok_b_meta_d = TOK_B;
    ts_b_d       = tok_b_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q - 8'd1;
    gnt_b_d      = gnt_b_q;
    last_b_d     = last_b_q;
    sel_d        = sel_q;
    word_cnt_d   = word_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    strobe_d     = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    req_a        = ENABLE & EN_A & ts_a_q;
    req_b        = ENABLE & EN_B & ts_b_q;
    ts_gnt       = gnt_b_q ? ts_b_q : ts_a_q;
    word_inc     = word_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (req_a | req_b) begin
          // On a tie the flavour not served last wins.
          gnt_b_d    = req_b & (~req_a | ~last_b_q);
          last_b_d   = gnt_b_d;
          sel_d      = gnt_b_d;
          word_cnt_d = 16'd0;
          state_d    = ST_FREEZE;
          cnt_d      = LEN_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_READ_HI;
          cnt_d   = LEN_HI;
        end
      end
      ST_READ_HI: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_READ_LO;
          cnt_d   = LEN_LO;
        end
      end
      ST_READ_LO: begin
        if (cnt_q == 8'd1) begin
          strobe_d   = 1'b1;
          word_cnt_d = word_inc;
          if (word_inc == WORD_LIMIT) begin
            overflow_d = 1'b1;
            state_d    = ST_RELEASE;
          end else if (ts_gnt) begin
            state_d = ST_READ_HI;
            cnt_d   = LEN_HI;
          end else begin
            state_d = ST_RELEASE;
          end
          if (state_d == ST_RELEASE) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            cnt_d        = LEN_REL;
          end
        end
      end
      ST_RELEASE: begin
        if (cnt_q == 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip lines are registered from the next state so they align with state entry.
    frame_active = (state_d == ST_FREEZE) | (state_d == ST_READ_HI) | (state_d == ST_READ_LO);
    freeze_a_d   = frame_active & ~gnt_b_d;
    freeze_b_d   = frame_active & gnt_b_d;
    read_a_d     = (state_d == ST_READ_HI) & ~gnt_b_d;
    read_b_d     = (state_d == ST_READ_HI) & gnt_b_d;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      tok_a_meta_q <= 1'b0;
      ts_a_q       <= 1'b0;
      tok_b_meta_q <= 1'b0;
      ts_b_q       <= 1'b0;
      gnt_b_q      <= 1'b0;
      last_b_q     <= 1'b1;
      sel_q        <= 1'b0;
      freeze_a_q   <= 1'b0;
      freeze_b_q   <= 1'b0;
      read_a_q     <= 1'b0;
      read_b_q     <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      word_cnt_q   <= 16'd0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tok_a_meta_q <= tok_a_meta_d;
      ts_a_q       <= ts_a_d;
      tok_b_meta_q <= tok_b_meta_d;
      ts_b_q       <= ts_b_d;
      gnt_b_q      <= gnt_b_d;
      last_b_q     <= last_b_d;
      sel_q        <= sel_d;
      freeze_a_q   <= freeze_a_d;
      freeze_b_q   <= freeze_b_d;
      read_a_q     <= read_a_d;
      read_b_q     <= read_b_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      word_cnt_q   <= word_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign FREEZE_A    = freeze_a_q;
  assign FREEZE_B    = freeze_b_q;
  assign READ_A      = read_a_q;
  assign READ_B      = read_b_q;
  assign SEL         = sel_q;
  assign DATA_STROBE = strobe_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;
  assign OVERFLOW    = overflow_q;
  assign WORD_CNT    = word_cnt_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_tjmono_readout_ctrl.sv
// tb/tb_tjmono_readout_ctrl.sv - scoreboard bench for tjmono_readout_ctrl
// Chip models emit token bursts; a frame-level model predicts strobes and frames.
module tb_tjmono_readout_ctrl;

  localparam int MAX_W = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0, EN_A = 1'b0, EN_B = 1'b0;
  logic        TOK_A, TOK_B;
  logic        FREEZE_A, FREEZE_B, READ_A, READ_B, SEL;
  logic        DATA_STROBE, BUSY, FRAME_DONE, OVERFLOW;
  logic [15:0] WORD_CNT, FRAME_CNT;

  tjmono_readout_ctrl #(.MAX_WORDS(MAX_W)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .EN_A(EN_A), .EN_B(EN_B),
    .TOK_A(TOK_A), .TOK_B(TOK_B),
    .FREEZE_A(FREEZE_A), .FREEZE_B(FREEZE_B), .READ_A(READ_A), .READ_B(READ_B),
    .SEL(SEL), .DATA_STROBE(DATA_STROBE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .OVERFLOW(OVERFLOW), .WORD_CNT(WORD_CNT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic b; int idx; } word_t;
  typedef struct { logic b; int n; logic ovf; int fcnt; } frame_t;

  word_t  exp_words[$];
  frame_t exp_frames[$];
  int     checks = 0, errors = 0;
  int     words_a = 0, words_b = 0, add_a = 0, add_b = 0;
  logic   last_b_m = 1'b1;
  int     frame_cnt_m = 0;
  int     fd_count = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame-level model: whole bursts, alternating on ties, cut into MAX_W-word frames.
  task automatic plan_frames(input int na_i, input int nb_i);
    int   na, nb, n;
    logic b, ovf;
    na = na_i;
    nb = nb_i;
    while (na > 0 || nb > 0) begin
      if (na > 0 && nb > 0) b = ~last_b_m;
      else b = (nb > 0);
      n   = b ? nb : na;
      ovf = (n >= MAX_W);
      if (ovf) n = MAX_W;
      if (b) nb -= n;
      else na -= n;
      last_b_m = b;
      frame_cnt_m++;
      for (int i = 1; i <= n; i++) exp_words.push_back('{b: b, idx: i});
      exp_frames.push_back('{b: b, n: n, ovf: ovf, fcnt: frame_cnt_m});
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    repeat (2) @(negedge CLK);
    while ((words_a + words_b + add_a + add_b != 0 || BUSY === 1'b1 ||
            exp_words.size() != 0 || exp_frames.size() != 0) && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk("phase_complete", int'(n < 4000), 1);
    repeat (3) @(negedge CLK);
  endtask

  // Chip model: holds TOK while words remain, hands one word out per READ pulse.
  initial begin
    TOK_A = 1'b0;
    TOK_B = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (READ_A === 1'b1 && words_a > 0) words_a--;
      if (READ_B === 1'b1 && words_b > 0) words_b--;
      words_a += add_a;
      add_a = 0;
      words_b += add_b;
      add_b = 0;
      TOK_A = (words_a > 0);
      TOK_B = (words_b > 0);
    end
  end

  // Monitor: pops the scoreboard on strobes/frame ends and checks pulse timing.
  initial begin
    word_t  w;
    frame_t f;
    int     cyc, tok_cyc, freeze_cyc, read_rise_cyc, read_fall_cyc, fd_cyc;
    logic   arm, first_read, p_tok_a, p_tok_b, p_freeze, p_read, p_sel;
    logic   freeze_any, read_any;
    cyc = 0; tok_cyc = 0; freeze_cyc = 0; read_rise_cyc = 0; read_fall_cyc = -100;
    fd_cyc = -100; arm = 1'b0; first_read = 1'b0;
    p_tok_a = 1'b0; p_tok_b = 1'b0; p_freeze = 1'b0; p_read = 1'b0; p_sel = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      freeze_any = FREEZE_A | FREEZE_B;
      read_any   = READ_A | READ_B;
      if (RST === 1'b0) begin
        if (((TOK_A && !p_tok_a) || (TOK_B && !p_tok_b)) && !p_tok_a && !p_tok_b &&
            !BUSY && ENABLE && EN_A && EN_B) begin
          arm = 1'b1;
          tok_cyc = cyc;
        end
        if (SEL !== p_sel) chk("sel_only_at_grant", int'(freeze_any && !p_freeze), 1);
        if (freeze_any && !p_freeze) begin
          if (arm) chk("tok_to_freeze", cyc - tok_cyc, 3);
          arm = 1'b0;
          chk("grant_word_cnt_clear", WORD_CNT, 0);
          freeze_cyc = cyc;
          first_read = 1'b1;
        end
        if (read_any && !p_read) begin
          if (first_read) chk("freeze_to_read", cyc - freeze_cyc, 4);
          else chk("read_period", cyc - read_rise_cyc, 4);
          first_read = 1'b0;
          read_rise_cyc = cyc;
        end
        if (!read_any && p_read) begin
          chk("read_width", cyc - read_rise_cyc, 1);
          read_fall_cyc = cyc;
        end
        chk("one_flavour_only", int'((FREEZE_A & FREEZE_B) | (READ_A & READ_B) |
                                     (READ_A & ~FREEZE_A) | (READ_B & ~FREEZE_B)), 0);
        if (freeze_any) chk("sel_matches_freeze", SEL, FREEZE_B);
        if (DATA_STROBE) begin
          chk("strobe_after_read", cyc - read_fall_cyc, 3);
          if (exp_words.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe sel=%0d word_cnt=%0d required=no strobe", SEL, WORD_CNT);
          end else begin
            w = exp_words.pop_front();
            chk("strobe_sel", SEL, w.b);
            chk("strobe_word_cnt", WORD_CNT, w.idx);
          end
        end
        if (FRAME_DONE) begin
          fd_count++;
          fd_cyc = cyc;
          if (exp_frames.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done sel=%0d words=%0d required=no frame", SEL, WORD_CNT);
          end else begin
            f = exp_frames.pop_front();
            chk("frame_sel", SEL, f.b);
            chk("frame_words", WORD_CNT, f.n);
            chk("frame_overflow", OVERFLOW, f.ovf);
            chk("frame_cnt", FRAME_CNT, f.fcnt);
          end
        end
        if (OVERFLOW) chk("overflow_with_done", FRAME_DONE, 1);
        if (cyc == fd_cyc + 1) chk("release_hold", {29'd0, BUSY, freeze_any, read_any}, 4);
        if (cyc == fd_cyc + 2) chk("release_len", BUSY, 0);
      end
      p_tok_a = TOK_A; p_tok_b = TOK_B; p_freeze = freeze_any; p_read = read_any; p_sel = SEL;
    end
  end

  initial begin
    int n, fd0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {23'd0, FREEZE_A, FREEZE_B, READ_A, READ_B, SEL,
                          DATA_STROBE, BUSY, FRAME_DONE, OVERFLOW}, 0);
    chk("reset_word_cnt", WORD_CNT, 0);
    chk("reset_frame_cnt", FRAME_CNT, 0);
    RST = 1'b0; ENABLE = 1'b1; EN_A = 1'b1; EN_B = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_after_reset", BUSY, 0);

    plan_frames(1, 0); add_a = 1; wait_done();
    chk("single_word_count", WORD_CNT, 1);
    chk("single_frame_count", FRAME_CNT, 1);

    plan_frames(0, 5); add_b = 5; wait_done();
    chk("b_burst_words", WORD_CNT, 5);

    plan_frames(16, 16); add_a = 16; add_b = 16; wait_done();
    chk("alternation_frames", FRAME_CNT, frame_cnt_m);

    plan_frames(10, 0); add_a = 10; wait_done();
    chk("regrant_after_overflow_words", WORD_CNT, 2);

    // ENABLE dropped mid-frame: frame completes, no new grant while disabled.
    plan_frames(6, 0); add_a = 6;
    n = 0;
    while (!(BUSY === 1'b1 && WORD_CNT == 16'd2) && n < 500) begin @(negedge CLK); n++; end
    chk("enable_drop_reached", int'(n < 500), 1);
    ENABLE = 1'b0; add_b = 4; fd0 = fd_count; n = 0;
    while (fd_count == fd0 && n < 500) begin @(negedge CLK); n++; end
    chk("enable_drop_frame_end", int'(n < 500), 1);
    chk("enable_drop_words", WORD_CNT, 6);
    repeat (2) @(negedge CLK);
    repeat (20) begin @(negedge CLK); chk("no_grant_enable_low", BUSY, 0); end
    ENABLE = 1'b1; EN_B = 1'b0;
    repeat (20) begin @(negedge CLK); chk("no_grant_en_b_low", BUSY, 0); end
    plan_frames(0, 4); EN_B = 1'b1; wait_done();

    // Reset pulsed during READ_HI of a 3-word burst.
    add_a = 3; n = 0;
    while (READ_A !== 1'b1 && n < 500) begin @(negedge CLK); n++; end
    chk("rst_read_reached", int'(n < 500), 1);
    #1 RST = 1'b1;
    #1;
    chk("rst_lines_low", {25'd0, FREEZE_A, FREEZE_B, READ_A, READ_B, BUSY, DATA_STROBE, FRAME_DONE}, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);
    last_b_m = 1'b1; frame_cnt_m = 0;
    @(negedge CLK);
    RST = 1'b0;
    plan_frames(2, 0); wait_done();
    chk("post_rst_frame_cnt", FRAME_CNT, frame_cnt_m);

    for (int r = 0; r < 8; r++) begin
      int na, nb;
      na = $urandom_range(0, 13);
      nb = $urandom_range(0, 13);
      plan_frames(na, nb); add_a = na; add_b = nb; wait_done();
      chk("random_frame_cnt", FRAME_CNT, frame_cnt_m);
    end

    chk("words_left", exp_words.size(), 0);
    chk("frames_left", exp_frames.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tjmono_readout_ctrl.md
Name: tjmono_readout_ctrl

Overview:
Readout sequencer for a TJ-Monopix chip with two flavours (A and B), each with its own TOKEN/FREEZE/READ lines. It arbitrates round-robin between flavours that raise TOKEN, then runs the freeze / read-pulse / release sequence. It drives SEL, which steers the shared OUT/TOK mux into the data receiver, and a DATA_STROBE that tells the receiver when to capture a word. It sits between the GPIO/configuration layer and the data receiver, running on the 40 MHz readout clock.

Parameters:
FREEZE_DLY, 4, cycles FREEZE is held before the first READ (1..255)
READ_HI_LEN, 1, cycles READ stays high per word (1..255)
READ_LO_LEN, 3, cycles READ stays low after each pulse (3..255; includes token resync)
RELEASE_LEN, 2, cycles FREEZE stays low after a frame before any new grant (1..255)
MAX_WORDS, 1024, words per frame before forced release (1..65535)

Ports:
CLK  in  1  readout clock, all logic on posedge
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  global run enable; deassertion takes effect only at a frame boundary
EN_A  in  1  flavour A eligible for grant
EN_B  in  1  flavour B eligible for grant
TOK_A  in  1  chip token A, asynchronous to CLK
TOK_B  in  1  chip token B, asynchronous to CLK
FREEZE_A  out  1  freeze to flavour A
FREEZE_B  out  1  freeze to flavour B
READ_A  out  1  read pulse to flavour A
READ_B  out  1  read pulse to flavour B
SEL  out  1  0 = A path selected, 1 = B path selected
DATA_STROBE  out  1  one-cycle pulse: capture the current word
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse when a frame ends
OVERFLOW  out  1  one-cycle pulse when a frame is cut at MAX_WORDS
WORD_CNT  out  16  words read in the current or most recent frame
FRAME_CNT  out  16  completed frames, wraps at 0xFFFF -> 0

Behaviour:
- Reset values: all outputs are 0, the state is IDLE, and last_served = B (so A wins the first tie).
- TOK_A/TOK_B each pass through a 2-flop synchronizer. All decisions use the synchronized tokens (tsA, tsB), which lag the inputs by 2 cycles.
- The FSM has five states: IDLE, FREEZE, READ_HI, READ_LO, RELEASE. A down-counter loads the state length on entry; the state exits when the counter reaches 1.
- IDLE:
  - Candidates: reqA = ENABLE & EN_A & tsA; reqB = ENABLE & EN_B & tsB.
  - If only one candidate requests, grant it. If both request, grant the flavour other than last_served.
  - On a grant: SEL, granted_flavour and last_served update on the same edge; WORD_CNT clears to 0; go to FREEZE.
  - If no candidate requests, stay in IDLE.
- SEL is constant from the grant until the next grant; it never changes outside IDLE.
- FREEZE (FREEZE_DLY cycles): FREEZE_x of the granted flavour is high. It stays high through READ_HI and READ_LO. The other flavour's FREEZE/READ lines stay 0 throughout.
- READ_HI (READ_HI_LEN cycles): READ_x of the granted flavour is high. Exit to READ_LO.
- READ_LO (READ_LO_LEN cycles): READ_x is low. On the last cycle:
  - DATA_STROBE = 1 and WORD_CNT increments.
  - Next state is chosen using the post-increment count:
    - WORD_CNT == MAX_WORDS: OVERFLOW = 1, go to RELEASE.
    - else tsx still high: go to READ_HI.
    - else go to RELEASE.
- RELEASE (RELEASE_LEN cycles): all FREEZE/READ lines are 0. On the first cycle, FRAME_DONE = 1 and FRAME_CNT increments. Then go to IDLE.
- Latency: from a TOK rise with the FSM idle to FREEZE rising is 3 cycles (2 sync + 1 grant). From FREEZE rising to READ rising is FREEZE_DLY cycles.
- ENABLE or EN_x deasserted mid-frame: the current frame completes normally; only new grants are blocked.
- A token that drops during FREEZE or READ_HI is ignored until the READ_LO decision point. At least one word is always read per granted frame.
- Token toggling in IDLE with no grant: no output change.
- RST asserted mid-frame: all outputs go to 0 immediately (asynchronous) and the FSM returns to IDLE. No FRAME_DONE is issued.
- Both tokens held high continuously: grants strictly alternate A, B, A, ...

Test Plan:
- Reset, then TOK_A = 1 for 1 word (tsA falls before the first READ_LO decision), defaults. Required:
  - FREEZE_A rises 3 cycles after TOK_A.
  - READ_A pulse is 1 cycle wide, 4 cycles after FREEZE_A.
  - DATA_STROBE comes 3 cycles after the READ fall.
  - FRAME_DONE follows; WORD_CNT = 1 and FRAME_CNT = 1.
- TOK_B held high for 5 words, then dropped. Required:
  - SEL = 1 for the whole frame.
  - Exactly 5 READ_B pulses, period 4 cycles, and 5 DATA_STROBE pulses.
  - READ_A and FREEZE_A stay at 0; WORD_CNT = 5.
- TOK_A and TOK_B both held high, 1 word per frame, run 4 frames. Required: grant order A, B, A, B and FRAME_CNT = 4.
- MAX_WORDS = 8 with TOK_A held high. Required:
  - 8 strobes, then an OVERFLOW pulse, FRAME_DONE, and a RELEASE of 2 cycles.
  - Then a regrant to A with WORD_CNT restarting from 0.
- ENABLE dropped during the 3rd word of a 6-word frame. Required:
  - The frame finishes all 6 words.
  - No new grant while ENABLE = 0, even with tokens high.
- RST pulsed during READ_HI. Required:
  - READ/FREEZE go to 0 within the same cycle and BUSY = 0.
  - FRAME_CNT keeps no partial increment; after release, a new grant succeeds.
